// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; returns at least 1 for n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_half.sv
// Half subtractor: x - y gives the difference bit d and the borrow-out bo.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, one bit per clock)
// with a valid/ready operand port and a held valid/ready result port.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bq_q, bq_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;

  logic d1, bo1, d_bit, bo2, bnext;

  // Full subtractor: (a0 - b0) first, then subtract the carried-in borrow.
  half_subtractor u_hs_ab (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .d  (d1),
    .bo (bo1)
  );

  half_subtractor u_hs_bq (
    .x  (d1),
    .y  (bq_q),
    .d  (d_bit),
    .bo (bo2)
  );

  assign bnext = bo1 | bo2;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bq_d     = bq_q;
    borrow_d = borrow_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          bq_d    = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {d_bit, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        bq_d    = bnext;
        count_d = count_q + CW'(1);
        // Published result only changes here, so diff/borrow hold across later runs.
        if (count_q == CW'(WIDTH - 1)) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bnext;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bq_q     <= 1'b0;
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bq_q     <= bq_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed cases
// and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic       rst8_n = 1'b0;
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, borrow8;
  logic [7:0] a8 = '0, b8 = '0, diff8;

  // 4-bit instance
  logic       rst4_n = 1'b0;
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, borrow4;
  logic [3:0] a4 = '0, b4 = '0, diff4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .borrow(borrow4)
  );

  exp_t exp8_q[$];
  exp_t exp4_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitors: a result is consumed on the negedge before its handshake edge.
  always @(negedge clk) begin
    if (rst8_n && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        chk("dut8 unexpected result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp8_q.pop_front();
        chk("dut8 diff", {24'd0, diff8}, {24'd0, e.diff});
        chk("dut8 borrow", {31'd0, borrow8}, {31'd0, e.borrow});
      end
    end
  end

  always @(negedge clk) begin
    if (rst4_n && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        chk("dut4 unexpected result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp4_q.pop_front();
        chk("dut4 diff", {28'd0, diff4}, {24'd0, e.diff});
        chk("dut4 borrow", {31'd0, borrow4}, {31'd0, e.borrow});
      end
    end
  end

  // Issue one 8-bit operation; returns on the negedge where out_valid is first seen.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready8) chk("dut8 in_ready timeout", 32'd0, 32'd1);
    a8 = av; b8 = bv; in_valid8 = 1'b1;
    e.diff = ed; e.borrow = eb;
    exp8_q.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55;   // operands must already be captured
    @(negedge clk);
    chk("dut8 in_ready after accept", {31'd0, in_ready8}, 32'd0);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("dut8 latency", lat, 32'd8);
  endtask

  // With out_ready high, check the cycle after the handshake.
  task automatic finish8();
    @(posedge clk); #1;
    chk("dut8 in_ready after handshake", {31'd0, in_ready8}, 32'd1);
    chk("dut8 out_valid after handshake", {31'd0, out_valid8}, 32'd0);
  endtask

  initial begin
    #1;
    chk("reset in_ready", {31'd0, in_ready8}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid8}, 32'd0);
    chk("reset diff", {24'd0, diff8}, 32'd0);
    chk("reset borrow", {31'd0, borrow8}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst8_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", {31'd0, in_ready8}, 32'd1);
    chk("post-reset out_valid", {31'd0, out_valid8}, 32'd0);

    // Basic, wraparound and equal operands
    op8(8'h35, 8'h12, 8'h23, 1'b0); finish8();
    op8(8'h00, 8'h01, 8'hFF, 1'b1); finish8();
    op8(8'hFF, 8'hFF, 8'h00, 1'b0); finish8();

    // Backpressure with a stray in_valid while the result is held
    out_ready8 = 1'b0;
    op8(8'h80, 8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end else begin
        in_valid8 = 1'b0;
      end
      @(negedge clk);
      chk("hold out_valid", {31'd0, out_valid8}, 32'd1);
      chk("hold diff", {24'd0, diff8}, 32'h01);
      chk("hold borrow", {31'd0, borrow8}, 32'd0);
      chk("hold in_ready", {31'd0, in_ready8}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    finish8();

    // Operands scrambled during RUN inside op8
    op8(8'h10, 8'h05, 8'h0B, 1'b0); finish8();

    // Asynchronous reset four cycles into an operation
    a8 = 8'h35; b8 = 8'h12; in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst8_n = 1'b0;
    #1;
    chk("abort out_valid", {31'd0, out_valid8}, 32'd0);
    chk("abort diff", {24'd0, diff8}, 32'd0);
    chk("abort borrow", {31'd0, borrow8}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready8}, 32'd1);
    exp8_q.delete();
    @(posedge clk); #1 rst8_n = 1'b1;
    @(posedge clk); #1;
    chk("after abort in_ready", {31'd0, in_ready8}, 32'd1);
    op8(8'h35, 8'h12, 8'h23, 1'b0); finish8();

    // WIDTH=4 exhaustive, back-to-back
    begin
      int last;
      int acc;
      int n;
      last = -1;
      for (int i = 0; i < 256; i++) begin
        int   av, bv;
        exp_t e;
        av = i / 16; bv = i % 16;
        n = 0;
        while (!in_ready4 && n < 50) begin
          @(posedge clk); #1; n++;
        end
        if (!in_ready4) chk("dut4 in_ready timeout", 32'd0, 32'd1);
        a4 = av[3:0]; b4 = bv[3:0]; in_valid4 = 1'b1;
        e.diff = 8'((av - bv + 16) % 16);
        e.borrow = (av < bv);
        exp4_q.push_back(e);
        @(posedge clk); #1;
        acc = cyc;
        in_valid4 = 1'b0;
        if (last >= 0) chk("dut4 op spacing", acc - last, 32'd6);
        last = acc;
      end
    end

    repeat (12) @(posedge clk);
    #1;
    chk("dut8 scoreboard drained", exp8_q.size(), 32'd0);
    chk("dut4 scoreboard drained", exp4_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog timeout");
  end

endmodule
